poly_eval_pipe: RTL and testbench
=================================

Name: poly_eval_pipe

Overview:
- Parametrised, pipelined Horner-form polynomial evaluator. It is the successor to the fixed 8-bit quadratic atan approximator.
- Supports configurable input, coefficient and output widths; degree 1..4; runtime-programmable coefficients with atomic commit; valid/ready backpressure; rounding and output saturation.
- Sits in the task_3 arithmetic datapath between the ratio/normalisation stage and the angle post-processing logic.

Parameters:
- DIN_W, 8: input width; unsigned Q0.DIN_W fraction, x in [0,1).
- COEF_W, 16: signed coefficient width.
- COEF_FRAC, 14: fractional bits of the coefficients.
- DEGREE, 2: polynomial degree, legal range 1..4; there are DEGREE+1 coefficients.
- DOUT_W, 16: signed output width.
- DOUT_FRAC, 13: fractional bits of the output. Must satisfy DOUT_FRAC <= COEF_FRAC.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- coef_we, in, 1: write enable for the shadow coefficient bank.
- coef_addr, in, 3: coefficient index k (c_k); writes with k > DEGREE are ignored.
- coef_wdata, in, COEF_W: coefficient value, signed.
- coef_commit, in, 1: single-cycle pulse requesting shadow-to-active copy.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: block can accept a sample this cycle.
- in_data, in, DIN_W: x.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_data, out, DOUT_W: p(x) in signed Q(DOUT_W-DOUT_FRAC).DOUT_FRAC.
- out_sat, out, 1: out_data was clamped; qualified by out_valid.
- busy, out, 1: at least one sample is in flight, or a commit is pending.

Behaviour:
- Function: p(x) = sum c_k·x^k, evaluated in Horner form. acc_0 = c_DEGREE; acc_j = round(acc_{j-1}·x) + c_{DEGREE-j}, for j = 1..DEGREE.
- Per-stage arithmetic:
  - The product has COEF_FRAC+DIN_W fractional bits. Add 2^(DIN_W-1), then arithmetic right shift by DIN_W (round-half-up).
  - Accumulator width is ACC_W = COEF_W+3 signed. No overflow is possible since |x| < 1 and DEGREE <= 4.
- Output conversion:
  - Add 2^(COEF_FRAC-DOUT_FRAC-1) when the shift is nonzero, then arithmetic shift right by COEF_FRAC-DOUT_FRAC.
  - Saturate to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]. out_sat=1 iff clamped.
- Pipeline:
  - Input register, then DEGREE Horner stages; the output register is the last stage.
  - Latency is DEGREE+1 cycles from the in_valid&&in_ready edge to out_valid, when unstalled.
  - Throughput is 1 sample/cycle.
- Flow control:
  - Global enable en = !out_valid || out_ready. The whole pipeline, including valid bits, advances only when en=1.
  - Bubbles are not collapsed.
  - Hold rule: out_data and out_sat hold while out_valid && !out_ready.
  - No sample is dropped or duplicated; output order equals input order.
- in_ready = en && (state == RUN).
- Coefficient banks:
  - coef_we writes the shadow bank in any state, every cycle.
  - Each sample is evaluated with the active bank captured at acceptance. Each stage carries the coefficient it needs.
  - A sample never mixes the old and new coefficient sets.
- FSM (RUN, DRAIN, COMMIT):
  - RUN: coef_commit → DRAIN. The sample accepted in the same cycle is still accepted, since in_ready for that cycle was computed from RUN.
  - DRAIN: in_ready=0. When no valid bit is set in any stage and out_valid=0 → COMMIT.
  - COMMIT: copy shadow to active in one cycle → RUN. in_ready=0 in this cycle.
  - coef_commit in DRAIN or COMMIT is absorbed (no second commit).
  - coef_we in the same cycle as the COMMIT copy: the new word reaches shadow only; active gets the pre-write value.
- busy = (state != RUN) || any stage valid || out_valid.
- Reset (async assert, deassert synchronous to clk):
  - in_ready=0 during reset; out_valid=0, out_data=0, out_sat=0, busy=0.
  - state=RUN; shadow and active banks = 0; all pipeline valid bits = 0.
  - Reset mid-operation discards all in-flight samples and any pending commit.

Decomposition:
- Package poly_eval_pkg:
  - state enum {RUN, DRAIN, COMMIT}.
  - Function acc_w(COEF_W).
  - Function rnd_shr(value, shift): round-half-up arithmetic shift.
  - Function sat(value, width): returns the clamped value and a flag.
  - Constant MAX_DEGREE = 4.
- Sub-module poly_horner_stage:
  - One multiply-round-add register stage carrying valid, x, the remaining coefficients and acc.
  - Generated DEGREE times.
  - Top level holds the banks, FSM, input register and output conversion.

Test Plan:
- Identity test: DEGREE=2, c={0,16384,0}, commit, in_data=128 → out_data=4096, out_sat=0, out_valid exactly 3 cycles after acceptance.
- Quadratic test: c2=-4096, c1=16384, c0=0; in_data=64 → out_data=1920. Then in_data=0 → out_data=0.
- Saturation test: c0=c1=c2=32767, in_data=255 → out_data=32767, out_sat=1. Negate all coefficients (-32767) → out_data=-32768, out_sat=1.
- Backpressure test: stream 20 samples with random in_valid, and out_ready low for 5 consecutive cycles mid-stream → all 20 results in order, each matching the reference model; out_data stable while stalled.
- Commit mid-stream test: 3 samples in flight, coef_commit pulse with a new shadow set → in_ready=0 until the pipeline is empty plus 1 commit cycle. In-flight samples use the old set; the first post-commit sample uses the new set.
- Reset test: assert rst asynchronously with out_valid=1 and stages full → out_valid, busy and out_data are 0 immediately. After deassert, identity input x=128 → out_data=0 (active bank cleared).

Source files
------------

// File: rtl/poly_eval_pkg.sv
// Shared types and arithmetic helpers for the pipelined Horner polynomial evaluator.
package poly_eval_pkg;

    localparam int unsigned MAX_DEGREE = 4;

    typedef enum logic [1:0] {StRun, StDrain, StCommit} state_e;

    typedef struct packed {
        logic signed [63:0] val;
        logic               clamped;
    } sat_t;

    // Two guard bits plus sign headroom cover |p(x)| for |x| < 1 and degree <= 4.
    function automatic int unsigned acc_w(input int unsigned coef_w);
        return coef_w + 3;
    endfunction

    function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] value,
                                                   input int unsigned       shift);
        logic signed [63:0] res;
        if (shift == 0) begin
            res = value;
        end else begin
            res = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        return res;
    endfunction

    function automatic sat_t sat(input logic signed [63:0] value, input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t               res;
        hi          = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo          = -(64'sd1 <<< (width - 1));
        res.val     = value;
        res.clamped = 1'b0;
        if (value > hi) begin
            res.val     = hi;
            res.clamped = 1'b1;
        end else if (value < lo) begin
            res.val     = lo;
            res.clamped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/poly_horner_stage.sv
// One Horner step: acc_o = round(acc_i * x) + c[IDX], registered with the sample's x and bank.
module poly_horner_stage
    import poly_eval_pkg::*;
#(
    parameter int unsigned DIN_W  = 8,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned ACC_W  = acc_w(COEF_W),
    parameter int unsigned NCOEF  = 3,
    parameter int unsigned IDX    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          valid_i,
    input  logic [DIN_W-1:0]              x_i,
    input  logic [NCOEF-1:0][COEF_W-1:0]  coefs_i,
    input  logic signed [ACC_W-1:0]       acc_i,
    output logic                          valid_o,
    output logic [DIN_W-1:0]              x_o,
    output logic [NCOEF-1:0][COEF_W-1:0]  coefs_o,
    output logic signed [ACC_W-1:0]       acc_o
);

    localparam int unsigned PROD_W = ACC_W + DIN_W + 1;

    logic signed [PROD_W-1:0]      prod;
    logic                          valid_d, valid_q;
    logic [DIN_W-1:0]              x_d, x_q;
    logic [NCOEF-1:0][COEF_W-1:0]  coefs_d, coefs_q;
    logic signed [ACC_W-1:0]       acc_d, acc_q;

    always_comb begin
        // x is an unsigned fraction, so zero-extend before the signed multiply.
        prod    = PROD_W'(acc_i) * PROD_W'($signed({1'b0, x_i}));
        acc_d   = ACC_W'(rnd_shr(64'(prod), DIN_W)) + ACC_W'($signed(coefs_i[IDX]));
        valid_d = valid_i;
        x_d     = x_i;
        coefs_d = coefs_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            coefs_q <= '0;
            acc_q   <= '0;
        end else if (en) begin
            valid_q <= valid_d;
            x_q     <= x_d;
            coefs_q <= coefs_d;
            acc_q   <= acc_d;
        end
    end

    assign valid_o = valid_q;
    assign x_o     = x_q;
    assign coefs_o = coefs_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/poly_eval_pipe.sv
// Pipelined Horner polynomial evaluator: coefficient banks with atomic commit, input register,
// DEGREE Horner stages and a rounding/saturating output register, all under one stall enable.
module poly_eval_pipe
    import poly_eval_pkg::*;
#(
    parameter int unsigned DIN_W     = 8,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned COEF_FRAC = 14,
    parameter int unsigned DEGREE    = 2,
    parameter int unsigned DOUT_W    = 16,
    parameter int unsigned DOUT_FRAC = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_we,
    input  logic [2:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    input  logic              coef_commit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] out_data,
    output logic              out_sat,
    output logic              busy
);

    localparam int unsigned ACC_W     = acc_w(COEF_W);
    localparam int unsigned NCOEF     = DEGREE + 1;
    localparam int unsigned OUT_SHIFT = COEF_FRAC - DOUT_FRAC;

    typedef logic [NCOEF-1:0][COEF_W-1:0] bank_t;

    state_e            state_d, state_q;
    bank_t             shadow_d, shadow_q, active_d, active_q;
    logic              en;

    // Index 0 is the input register, index j the output of Horner stage j.
    logic [DEGREE:0]         stg_valid;
    logic [DIN_W-1:0]        stg_x     [DEGREE+1];
    bank_t                   stg_coefs [DEGREE+1];
    logic signed [ACC_W-1:0] stg_acc   [DEGREE+1];

    logic                    in_vld_d, in_vld_q;
    logic [DIN_W-1:0]        in_x_d, in_x_q;
    bank_t                   in_coefs_d, in_coefs_q;

    logic signed [63:0]      conv;
    sat_t                    sres;
    logic                    out_valid_d, out_valid_q;
    logic [DOUT_W-1:0]       out_data_d, out_data_q;
    logic                    out_sat_d, out_sat_q;
    logic                    unused_tail;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en && (state_q == StRun) && !rst;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        shadow_d = shadow_q;
        for (int k = 0; k < NCOEF; k++) begin
            if (coef_we && coef_addr == 3'(k)) begin
                shadow_d[k] = coef_wdata;
            end
        end
        unique case (state_q)
            StRun:    if (coef_commit) state_d = StDrain;
            StDrain:  if (!(|stg_valid) && !out_valid_q) state_d = StCommit;
            StCommit: begin
                // Registered shadow: a write landing this cycle stays in shadow only.
                active_d = shadow_q;
                state_d  = StRun;
            end
            default:  state_d = StRun;
        endcase
    end

    always_comb begin
        in_vld_d   = in_valid && in_ready;
        in_x_d     = in_data;
        in_coefs_d = active_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            shadow_q   <= '0;
            active_q   <= '0;
            in_vld_q   <= 1'b0;
            in_x_q     <= '0;
            in_coefs_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            if (en) begin
                in_vld_q   <= in_vld_d;
                in_x_q     <= in_x_d;
                in_coefs_q <= in_coefs_d;
            end
        end
    end

    assign stg_valid[0] = in_vld_q;
    assign stg_x[0]     = in_x_q;
    assign stg_coefs[0] = in_coefs_q;
    assign stg_acc[0]   = ACC_W'($signed(in_coefs_q[DEGREE]));

    for (genvar j = 1; j <= DEGREE; j++) begin : g_stage
        poly_horner_stage #(
            .DIN_W  (DIN_W),
            .COEF_W (COEF_W),
            .ACC_W  (ACC_W),
            .NCOEF  (NCOEF),
            .IDX    (DEGREE - j)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .valid_i (stg_valid[j-1]),
            .x_i     (stg_x[j-1]),
            .coefs_i (stg_coefs[j-1]),
            .acc_i   (stg_acc[j-1]),
            .valid_o (stg_valid[j]),
            .x_o     (stg_x[j]),
            .coefs_o (stg_coefs[j]),
            .acc_o   (stg_acc[j])
        );
    end

    always_comb begin
        conv        = rnd_shr(64'(stg_acc[DEGREE]), OUT_SHIFT);
        sres        = sat(conv, DOUT_W);
        out_valid_d = stg_valid[DEGREE];
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (stg_valid[DEGREE]) begin
            out_data_d = DOUT_W'(sres.val);
            out_sat_d  = sres.clamped;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign busy        = (state_q != StRun) || (|stg_valid) || out_valid_q;
    assign unused_tail = ^{stg_x[DEGREE], stg_coefs[DEGREE]};

endmodule

// File: tb/tb_poly_eval_pipe.sv
// Directed self-checking bench for poly_eval_pipe (DEGREE=2, Q0.8 in, Q2.14 coef, Q3.13 out).
module tb_poly_eval_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        coef_we, coef_commit;
    logic [2:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        out_sat, busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    poly_eval_pipe #(
        .DIN_W(8), .COEF_W(16), .COEF_FRAC(14), .DEGREE(2), .DOUT_W(16), .DOUT_FRAC(13)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .busy        (busy)
    );

    function automatic int fdiv(input longint p, input longint q);
        if (p >= 0) return int'(p / q);
        return int'(-((-p + q - 1) / q));
    endfunction

    // Reference: Horner with round-half-up per stage, then Q14 -> Q13 and clamp.
    function automatic int model(input int c0, input int c1, input int c2, input int x);
        longint acc;
        int     o;
        acc = c2;
        acc = fdiv(acc * x + 128, 256) + c1;
        acc = fdiv(acc * x + 128, 256) + c0;
        o   = fdiv(acc + 1, 2);
        if (o > 32767) o = 32767;
        if (o < -32768) o = -32768;
        return o;
    endfunction

    task automatic write_coef(input int addr, input int data);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 3'(addr);
        coef_wdata = 16'(data);
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    task automatic commit_wait();
        int left;
        @(negedge clk);
        coef_commit = 1'b1;
        @(negedge clk);
        coef_commit = 1'b0;
        left = 20;
        while (busy && left > 0) begin
            @(negedge clk);
            left--;
        end
        checks++;
        if (busy) $display("FAIL commit_timeout: busy=%0b required 0", busy);
        else passed++;
    endtask

    task automatic set_bank(input int c0, input int c1, input int c2);
        write_coef(0, c0);
        write_coef(1, c1);
        write_coef(2, c2);
        commit_wait();
    endtask

    task automatic run_sample(input int x, output logic [15:0] d, output logic s, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'(x);
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        d   = '0;
        s   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                d   = out_data;
                s   = out_sat;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({in_ready, out_valid, busy, out_sat} !== 4'b0000 || out_data !== 16'h0000) begin
            $display("FAIL reset_state: rdy/vld/busy/sat=%b data=%0d required 0000 and 0",
                     {in_ready, out_valid, busy, out_sat}, out_data);
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL post_reset_ready: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end else passed++;
    endtask

    task automatic test_identity();
        logic [15:0] d;
        logic        s;
        int          lat;
        write_coef(0, 0);
        write_coef(1, 16384);
        write_coef(2, 0);
        // Addresses above DEGREE must not alias onto real coefficients.
        write_coef(4, 8192);
        write_coef(7, 8192);
        commit_wait();
        run_sample(128, d, s, lat);
        checks++;
        if (d !== 16'd4096) $display("FAIL identity_data: got %0d required 4096", $signed(d));
        else passed++;
        checks++;
        if (s !== 1'b0) $display("FAIL identity_sat: got %b required 0", s);
        else passed++;
        checks++;
        if (lat != 3) $display("FAIL identity_latency: got %0d required 3", lat);
        else passed++;
    endtask

    task automatic test_quadratic();
        logic [15:0] d;
        logic        s;
        int          lat;
        set_bank(0, 16384, -4096);
        run_sample(64, d, s, lat);
        checks++;
        if (d !== 16'd1920 || s !== 1'b0) begin
            $display("FAIL quad_x64: got %0d sat %b required 1920 sat 0", $signed(d), s);
        end else passed++;
        run_sample(0, d, s, lat);
        checks++;
        if (d !== 16'd0 || s !== 1'b0) begin
            $display("FAIL quad_x0: got %0d sat %b required 0 sat 0", $signed(d), s);
        end else passed++;
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        logic        s;
        int          lat;
        set_bank(32767, 32767, 32767);
        run_sample(255, d, s, lat);
        checks++;
        if (d !== 16'h7fff || s !== 1'b1) begin
            $display("FAIL sat_pos: got %0d sat %b required 32767 sat 1", $signed(d), s);
        end else passed++;
        set_bank(-32767, -32767, -32767);
        run_sample(255, d, s, lat);
        checks++;
        if (d !== 16'h8000 || s !== 1'b1) begin
            $display("FAIL sat_neg: got %0d sat %b required -32768 sat 1", $signed(d), s);
        end else passed++;
    endtask

    task automatic test_backpressure();
        int xs  [20];
        int exp [20];
        int tx, rx, cyc;
        set_bank(0, 16384, -4096);
        for (int i = 0; i < 20; i++) begin
            xs[i]  = (i * 37 + 5) % 256;
            exp[i] = model(0, 16384, -4096, xs[i]);
        end
        tx  = 0;
        rx  = 0;
        cyc = 0;
        while (rx < 20 && cyc < 400) begin
            @(negedge clk);
            out_ready = !(cyc >= 12 && cyc < 17);
            if (tx < 20) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'(xs[tx]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                checks++;
                if ($signed(out_data) !== 16'(exp[rx])) begin
                    $display("FAIL bp_sample%0d: got %0d required %0d", rx, $signed(out_data),
                             exp[rx]);
                end else passed++;
                if (out_ready) rx++;
            end
            if (in_valid && in_ready) tx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rx != 20) $display("FAIL bp_count: got %0d results required 20", rx);
        else passed++;
    endtask

    task automatic test_commit_midstream();
        int xs  [4] = '{64, 128, 192, 128};
        int exp [4] = '{1920, 3584, 4992, 4096};
        int tx, rx, cyc, low;
        // Active stays quadratic; shadow is loaded with the identity set.
        write_coef(0, 0);
        write_coef(1, 16384);
        write_coef(2, 0);
        tx  = 0;
        rx  = 0;
        cyc = 0;
        low = 0;
        out_ready = 1'b1;
        while (rx < 4 && cyc < 100) begin
            @(negedge clk);
            in_valid    = (tx < 4);
            in_data     = 8'(xs[tx < 4 ? tx : 3]);
            coef_commit = (cyc == 2);
            #1;
            if (out_valid) begin
                checks++;
                if ($signed(out_data) !== 16'(exp[rx])) begin
                    $display("FAIL commit_sample%0d: got %0d required %0d", rx,
                             $signed(out_data), exp[rx]);
                end else passed++;
                rx++;
            end
            if (tx == 3 && !in_ready) low++;
            if (in_valid && in_ready) tx++;
            cyc++;
        end
        in_valid    = 1'b0;
        coef_commit = 1'b0;
        checks++;
        if (rx != 4) $display("FAIL commit_count: got %0d results required 4", rx);
        else passed++;
        // Drain sees 3 samples leave (plus one empty-detect cycle), then one commit cycle.
        checks++;
        if (low != 6) $display("FAIL commit_stall: in_ready low %0d cycles required 6", low);
        else passed++;
    endtask

    task automatic test_reset_midop();
        logic [15:0] d;
        logic        s;
        int          lat;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd64;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL prereset_full: out_valid=%b busy=%b required 1 1", out_valid, busy);
        end else passed++;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b000 || out_data !== 16'h0000) begin
            $display("FAIL reset_midop: vld/busy/rdy=%b data=%0d required 000 and 0",
                     {out_valid, busy, in_ready}, out_data);
        end else passed++;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        run_sample(128, d, s, lat);
        checks++;
        if (d !== 16'd0 || s !== 1'b0 || lat != 3) begin
            $display("FAIL reset_bank_cleared: got %0d sat %b lat %0d required 0 0 3",
                     $signed(d), s, lat);
        end else passed++;
    endtask

    initial begin
        rst         = 1'b1;
        coef_we     = 1'b0;
        coef_commit = 1'b0;
        coef_addr   = '0;
        coef_wdata  = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        test_reset();
        test_identity();
        test_quadratic();
        test_saturation();
        test_backpressure();
        test_commit_midstream();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
